fpga_input_loader: RTL
======================

FPGA_INPUT_LOADER -- requirements
Module: fpga_input_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable samples (D) needed to accept a key change; legal range 2..2^20.
REQ-002 Parameter FIFO_DEPTH, default 4, entry count of the operand FIFO; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_n  input  3  raw pushbuttons, active-low; bit0=enter, bit1=clear FIFO, bit2=clear overflow; asynchronous to clk.
REQ-006 sw  input  16  raw switch word, asynchronous to clk.
REQ-007 out_data  output  16  FIFO head word.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts head when out_valid && out_ready.
REQ-010 fifo_count  output  5  current occupancy, 0..FIFO_DEPTH.
REQ-011 overflow  output  1  sticky flag, enter press dropped while full.

Function
REQ-012 key_n and sw SHALL each pass a 2-flop synchronizer; all downstream logic uses synchronized values only.
REQ-013 Each key SHALL have an independent debouncer: stable state, counter; counter clears on any cycle sync value equals stable state; counter increments while they differ.
REQ-014 Stable state SHALL toggle, and counter clear, on the edge where the D-th consecutive differing sample is taken; glitches shorter than D cycles SHALL produce no change.
REQ-015 A press event SHALL be the edge on which a key's stable state goes released->pressed; exactly one event per physical press, none on release.
REQ-016 Enter event: synchronized sw SHALL be written to FIFO tail on that same edge if not full, or if full and a pop occurs the same edge.
REQ-017 Enter event while full with no simultaneous pop: word dropped, overflow set to 1 on that edge, FIFO unchanged.
REQ-018 Pop SHALL occur on each edge with out_valid && out_ready; out_ready ignored when empty.
REQ-019 Push and pop same edge when non-empty: fifo_count unchanged, order preserved.
REQ-020 Clear-FIFO event: fifo_count, read and write pointers to 0 on that edge; clear wins over a same-edge push or pop.
REQ-021 Clear-overflow event: overflow to 0; if an overflowing enter occurs the same edge, overflow SHALL be 1.
REQ-022 out_data SHALL equal the head entry when out_valid=1 and 16'h0000 when empty.
REQ-023 out_valid SHALL be registered-equivalent: high the cycle after the first write into an empty FIFO.
REQ-024 Latency: key_n[0] held low from edge 0 SHALL give out_valid=1 after edge 2+D, data = sw synchronized value at edge 2+D.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH nor underflows.

Reset
REQ-026 While reset=1 at an edge: fifo_count=0, out_valid=0, out_data=0, overflow=0, pointers=0, debounce counters=0, stable states=released, synchronizer flops=released/0.
REQ-027 reset SHALL take priority over every event; a press in progress at reset is discarded and requires a fresh D-cycle stable low after reset deasserts.
REQ-028 A key held low through reset deassertion SHALL generate one press event D+2 edges later.

Verification (D=4, FIFO_DEPTH=4)
REQ-029 sw=16'h1234, key_n[0] low from edge 0, out_ready=0 -> out_valid=1 after edge 6, out_data=16'h1234, fifo_count=1; release generates no second entry.
REQ-030 key_n[0] low pulses of 3 cycles, repeated -> fifo_count stays 0, out_valid stays 0.
REQ-031 Five enter presses with sw=1..5, out_ready=0 -> fifo_count=4, overflow=1, pops yield 1,2,3,4 then out_valid=0, out_data=0.
REQ-032 FIFO full, out_ready=1 held, enter with sw=16'hBEEF on pop edge -> no overflow, count stays 4, BEEF emerges last.
REQ-033 Clear-FIFO press with 3 entries and out_ready=1 same edge -> fifo_count=0, out_valid=0 next cycle; clear-overflow press -> overflow=0.
REQ-034 reset=1 mid-debounce (key low 2 cycles) with 2 entries stored -> all outputs 0 next cycle; key still held -> entry appears at edge 6 after reset falls.

Source files
------------

// File: rtl/fpga_input_loader.sv
// Pushbutton/switch operand loader: synchronizes raw keys and switches,
// debounces each key, and queues the switch word into a small FIFO on enter.
module fpga_input_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  key_n,
  input  logic [15:0] sw,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  fifo_count,
  output logic        overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]    key_s1_q, key_s2_q;
  logic [15:0]   sw_s1_q, sw_s2_q;
  logic [2:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    differ, hit, press;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, push, ovf_set, we;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q <= 3'b111;
      key_s2_q <= 3'b111;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Stable state flips on the D-th consecutive differing sample.
  always_comb begin
    differ   = '0;
    hit      = '0;
    press    = '0;
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]  = cnt_q[i];
      differ[i] = key_s2_q[i] != stable_q[i];
      hit[i]    = differ[i] &&
                  (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1));
      press[i]  = hit[i] && stable_q[i];
      if (hit[i])
        stable_d[i] = ~stable_q[i];
      if (!differ[i] || hit[i])
        cnt_d[i] = '0;
      else
        cnt_d[i] = cnt_q[i] + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 3'b111;
      for (int i = 0; i < 3; i++)
        cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 3; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid  = count_q != 5'd0;
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  assign full    = count_q == 5'(FIFO_DEPTH);
  assign pop     = out_valid && out_ready;
  assign push    = press[0] && (!full || pop);
  assign ovf_set = press[0] && full && !pop;
  assign we      = push && !press[1];

  // Clear-FIFO overrides any same-edge push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (press[1]) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      if (push)
        wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + 5'(push) - 5'(pop);
    end
    ovf_d = ovf_q;
    if (ovf_set)
      ovf_d = 1'b1;
    else if (press[2])
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem_q[wr_ptr_q] <= sw_s2_q;
  end

endmodule
